// File: rtl/addsub_multicycle.sv
// Multi-cycle two's-complement adder/subtractor: one CHUNK-bit slice per cycle, LSB first,
// with a registered inter-slice carry, optional saturation and N/Z/V flags.
module addsub_multicycle #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_sub,
    input  logic             sat,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             ovfl,
    output logic             neg,
    output logic             zero
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] SAT_MAX  = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN  = {1'b1, {(WIDTH - 1){1'b0}}};

    typedef enum logic {StIdle, StCalc} state_t;

    state_t           state_q;
    logic [IDXW-1:0]  idx_q;
    logic             carry_q;
    logic             sat_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] res_q;

    logic [CHUNK:0]   slice_sum;
    logic             msb_cin;
    logic             v;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] final_sum;

    // Operands shift right each cycle, so the active slice is always the low CHUNK bits and,
    // on the last cycle, bit CHUNK-1 is the operand MSB.
    always_comb begin
        slice_sum = {1'b0, opa_q[CHUNK-1:0]} + {1'b0, opb_q[CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, carry_q};
        res_next  = (res_q >> CHUNK) | (WIDTH'(slice_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
        msb_cin   = opa_q[CHUNK-1] ^ opb_q[CHUNK-1] ^ slice_sum[CHUNK-1];
        v         = msb_cin ^ slice_sum[CHUNK];
        final_sum = (sat_q && v) ? (opa_q[CHUNK-1] ? SAT_MIN : SAT_MAX) : res_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sat_q   <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            ovfl    <= 1'b0;
            neg     <= 1'b0;
            zero    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        opa_q   <= a;
                        opb_q   <= is_sub ? ~b : b;
                        carry_q <= is_sub;
                        sat_q   <= sat;
                        idx_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    opa_q   <= opa_q >> CHUNK;
                    opb_q   <= opb_q >> CHUNK;
                    carry_q <= slice_sum[CHUNK];
                    res_q   <= res_next;
                    idx_q   <= idx_q + IDXW'(1);
                    if (idx_q == LAST_IDX) begin
                        sum     <= final_sum;
                        ovfl    <= v;
                        neg     <= final_sum[WIDTH-1];
                        zero    <= (final_sum == '0);
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_multicycle.sv
// Self-checking bench for addsub_multicycle: three configurations (16/4, 16/16, 8/1),
// table vectors, handshake corner cases and a random sweep against a reference model.
module tb_addsub_multicycle;

    typedef struct packed {
        logic [15:0] sum;
        logic        ovfl;
        logic        neg;
        logic        zero;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        is_sub;
        logic        sat;
        exp_t        e;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [2:0]  start_v, is_sub_v, sat_v;
    logic [15:0] a_v [3];
    logic [15:0] b_v [3];
    logic [2:0]  busy_v, done_v, ovfl_v, neg_v, zero_v;
    logic [15:0] sum0, sum1;
    logic [7:0]  sum2;

    int   checks = 0;
    int   errors = 0;
    exp_t q [3][$];
    vec_t vecs [10];

    addsub_multicycle #(.WIDTH(16), .CHUNK(4)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
        .is_sub(is_sub_v[0]), .sat(sat_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .sum(sum0), .ovfl(ovfl_v[0]), .neg(neg_v[0]), .zero(zero_v[0])
    );

    addsub_multicycle #(.WIDTH(16), .CHUNK(16)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
        .is_sub(is_sub_v[1]), .sat(sat_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .sum(sum1), .ovfl(ovfl_v[1]), .neg(neg_v[1]), .zero(zero_v[1])
    );

    addsub_multicycle #(.WIDTH(8), .CHUNK(1)) dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .a(a_v[2][7:0]), .b(b_v[2][7:0]),
        .is_sub(is_sub_v[2]), .sat(sat_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .sum(sum2), .ovfl(ovfl_v[2]), .neg(neg_v[2]), .zero(zero_v[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int width_of(input int k);
        return (k == 2) ? 8 : 16;
    endfunction

    function automatic int lat_of(input int k);
        case (k)
            0:       return 4;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    function automatic logic [15:0] get_sum(input int k);
        case (k)
            0:       return sum0;
            1:       return sum1;
            default: return {8'h00, sum2};
        endcase
    endfunction

    function automatic longint sext(input logic [15:0] x, input int w);
        longint t;
        t = longint'(x) & ((64'sd1 <<< w) - 1);
        if (t[w-1]) t = t - (64'sd1 <<< w);
        return t;
    endfunction

    // Reference: exact signed arithmetic, then range test and clamp.
    function automatic exp_t model(input int w, input logic [15:0] x, input logic [15:0] y,
                                   input logic s, input logic st);
        exp_t   e;
        longint mx, mn, r;
        mx = (64'sd1 <<< (w - 1)) - 1;
        mn = -(64'sd1 <<< (w - 1));
        r  = s ? sext(x, w) - sext(y, w) : sext(x, w) + sext(y, w);
        e.ovfl = (r > mx) || (r < mn);
        if (st && e.ovfl) r = (r > mx) ? mx : mn;
        e.sum  = 16'(r & ((64'sd1 <<< w) - 1));
        e.neg  = e.sum[w-1];
        e.zero = (e.sum == 16'h0);
        return e;
    endfunction

    task automatic check(input bit cond, input string name, input longint act,
                         input longint req);
        checks++;
        if (!cond) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Called on a negedge; returns on the negedge after the start edge.
    task automatic issue(input int k, input logic [15:0] x, input logic [15:0] y,
                         input logic s, input logic st, input exp_t e);
        a_v[k] = x;
        b_v[k] = y;
        is_sub_v[k] = s;
        sat_v[k] = st;
        start_v[k] = 1'b1;
        q[k].push_back(e);
        @(negedge clk);
        start_v[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int exp_lat, input string name);
        int          n = 0;
        bit          ok = 1'b1;
        logic [15:0] held;
        held = get_sum(k);
        while (done_v[k] !== 1'b1 && n <= 64) begin
            if (busy_v[k] !== 1'b1 || get_sum(k) !== held) ok = 1'b0;
            @(negedge clk);
            n++;
        end
        check(done_v[k] === 1'b1 && n == exp_lat, {name, "_latency"}, n, exp_lat);
        check(ok, {name, "_busy_hold"}, ok, 1);
        check(busy_v[k] === 1'b0, {name, "_busy_at_done"}, busy_v[k], 0);
    endtask

    // Scoreboard: compare every done pulse with the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        exp_t g;
        for (int k = 0; k < 3; k++) begin
            if (done_v[k] === 1'b1) begin
                checks++;
                if (q[k].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done[%0d]: got done=1 want done=0", k);
                end else begin
                    e = q[k].pop_front();
                    g = '{sum: get_sum(k), ovfl: ovfl_v[k], neg: neg_v[k], zero: zero_v[k]};
                    if (g !== e) begin
                        errors++;
                        $display("FAIL result[%0d]: got sum=%h v=%b n=%b z=%b want sum=%h v=%b n=%b z=%b",
                                 k, g.sum, g.ovfl, g.neg, g.zero, e.sum, e.ovfl, e.neg, e.zero);
                    end
                end
            end
        end
    end

    initial begin
        exp_t        e;
        logic [15:0] x, y;
        logic        s, st;

        vecs[0] = '{16'h0005, 16'h0003, 1'b0, 1'b0, '{16'h0008, 1'b0, 1'b0, 1'b0}};
        vecs[1] = '{16'h0007, 16'h0002, 1'b1, 1'b0, '{16'h0005, 1'b0, 1'b0, 1'b0}};
        vecs[2] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, '{16'h1000, 1'b0, 1'b0, 1'b0}};
        vecs[3] = '{16'h1234, 16'h1234, 1'b1, 1'b0, '{16'h0000, 1'b0, 1'b0, 1'b1}};
        vecs[4] = '{16'h0008, 16'h0009, 1'b1, 1'b0, '{16'hFFFF, 1'b0, 1'b1, 1'b0}};
        vecs[5] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b0, 1'b0, 1'b1}};
        vecs[6] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b1, 1'b1, 1'b0}};
        vecs[7] = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b0, 1'b0}};
        vecs[8] = '{16'h8000, 16'h0001, 1'b1, 1'b0, '{16'h7FFF, 1'b1, 1'b0, 1'b0}};
        vecs[9] = '{16'h8000, 16'h0001, 1'b1, 1'b1, '{16'h8000, 1'b1, 1'b1, 1'b0}};

        rst = 1'b1;
        start_v = '0;
        is_sub_v = '0;
        sat_v = '0;
        for (int k = 0; k < 3; k++) begin
            a_v[k] = '0;
            b_v[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++)
            check(get_sum(k) == 16'h0 && {busy_v[k], done_v[k], ovfl_v[k], neg_v[k], zero_v[k]}
                  == 5'b0, $sformatf("reset_state[%0d]", k),
                  {get_sum(k), busy_v[k], done_v[k], ovfl_v[k], neg_v[k], zero_v[k]}, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            issue(0, vecs[i].a, vecs[i].b, vecs[i].is_sub, vecs[i].sat, vecs[i].e);
            wait_done(0, 4, $sformatf("vec%0d", i));
        end

        // Abort in the second CALC cycle; sum was 0x8000 so a clear is observable.
        @(negedge clk);
        issue(0, 16'h1111, 16'h2222, 1'b0, 1'b0, model(16, 16'h1111, 16'h2222, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b1;
        q[0].delete();
        @(negedge clk);
        rst = 1'b0;
        check(sum0 == 16'h0 && {busy_v[0], done_v[0], ovfl_v[0], neg_v[0], zero_v[0]} == 5'b0,
              "abort_outputs", {sum0, busy_v[0], done_v[0], ovfl_v[0], neg_v[0], zero_v[0]}, 0);
        repeat (8) @(negedge clk);
        issue(0, 16'h0100, 16'h0023, 1'b0, 1'b0, '{16'h0123, 1'b0, 1'b0, 1'b0});
        wait_done(0, 4, "after_abort");

        // rst wins over a simultaneous start.
        @(negedge clk);
        rst = 1'b1;
        a_v[0] = 16'h0005;
        start_v[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start_v[0] = 1'b0;
        check(busy_v[0] === 1'b0, "rst_over_start_busy", busy_v[0], 0);
        repeat (6) @(negedge clk);

        // Start while busy must be ignored.
        issue(0, 16'h0100, 16'h0023, 1'b0, 1'b0, '{16'h0123, 1'b0, 1'b0, 1'b0});
        a_v[0] = 16'h7FFF;
        b_v[0] = 16'h7FFF;
        is_sub_v[0] = 1'b1;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, 3, "ignore_start");
        repeat (6) @(negedge clk);

        // Back-to-back: start issued in the done cycle.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            issue(k, 16'h0F0F, 16'h00F1, 1'b0, 1'b0, '{16'h1000, 1'b0, 1'b0, 1'b0});
            wait_done(k, lat_of(k), $sformatf("b2b_first[%0d]", k));
            issue(k, 16'h0003, 16'h0005, 1'b1, 1'b0, '{16'hFFFE, 1'b0, 1'b1, 1'b0});
            wait_done(k, lat_of(k), $sformatf("b2b_second[%0d]", k));
        end

        // Saturating positive-max + 1 in each configuration.
        @(negedge clk);
        issue(0, 16'h7FFF, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b0, 1'b0});
        wait_done(0, 4, "satmax0");
        @(negedge clk);
        issue(1, 16'h7FFF, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b0, 1'b0});
        wait_done(1, 1, "satmax1");
        @(negedge clk);
        issue(2, 16'h007F, 16'h0001, 1'b0, 1'b1, '{16'h007F, 1'b1, 1'b0, 1'b0});
        wait_done(2, 8, "satmax2");
        @(negedge clk);
        issue(2, 16'h0080, 16'h0001, 1'b1, 1'b0, '{16'h007F, 1'b1, 1'b0, 1'b0});
        wait_done(2, 8, "negovf2");

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 25; i++) begin
                x  = 16'($urandom);
                y  = 16'($urandom);
                s  = 1'($urandom);
                st = 1'($urandom);
                e  = model(width_of(k), x, y, s, st);
                @(negedge clk);
                issue(k, x, y, s, st, e);
                wait_done(k, lat_of(k), $sformatf("rand[%0d][%0d]", k, i));
            end
        end

        repeat (10) @(negedge clk);
        for (int k = 0; k < 3; k++)
            check(q[k].size() == 0, $sformatf("queue_drained[%0d]", k), q[k].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
